// File: rtl/token_embedder.sv
// Token embedder: reads token IDs back from the encoder output SRAM and
// streams the matching embedding rows out on a valid/ready port.
module token_embedder #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int EMB_DIM    = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  cs,
   input  logic [ADDR_WIDTH:0]                   tok_count,
   output logic                                  tok_rd,
   output logic [ADDR_WIDTH-1:0]                 tok_addr,
   input  logic [DATA_WIDTH-1:0]                 tok_data,
   output logic                                  emb_rd,
   output logic [DATA_WIDTH+$clog2(EMB_DIM)-1:0] emb_addr,
   input  logic [DATA_WIDTH-1:0]                 emb_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [DATA_WIDTH-1:0]                 out_data,
   output logic                                  out_row_last,
   output logic                                  out_last,
   output logic                                  busy,
   output logic                                  done
);

   localparam int EW = $clog2(EMB_DIM);
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] MAX_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [CW-1:0] CNT_ONE = 1;
   localparam logic [ADDR_WIDTH-1:0] TI_ONE = 1;
   localparam logic [EW-1:0] EI_ONE = 1;
   localparam logic [EW-1:0] EI_LAST = EW'(EMB_DIM - 1);

   typedef enum logic [2:0] {
      IDLE, RD_TOK, WAIT_TOK, RD_EMB, WAIT_EMB, EMIT, DONE
   } state_t;

   state_t                     state, state_n;
   logic [ADDR_WIDTH-1:0]      ti, ti_n;
   logic [EW-1:0]              ei, ei_n;
   logic [DATA_WIDTH-1:0]      tok_id, tok_id_n;
   logic [CW-1:0]              cnt, cnt_n;
   logic [ADDR_WIDTH-1:0]      tok_addr_n;
   logic [DATA_WIDTH+EW-1:0]   emb_addr_n;
   logic [DATA_WIDTH-1:0]      data_n;
   logic                       valid_n, row_last_n, last_n;
   logic                       ti_last, ei_last;

   assign ti_last = ({1'b0, ti} == (cnt - CNT_ONE));
   assign ei_last = (ei == EI_LAST);

   assign tok_rd = (state == RD_TOK);
   assign emb_rd = (state == RD_EMB);
   assign done   = (state == DONE);
   assign busy   = (state != IDLE) && (state != DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ti           <= '0;
         ei           <= '0;
         tok_id       <= '0;
         cnt          <= '0;
         tok_addr     <= '0;
         emb_addr     <= '0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         out_row_last <= 1'b0;
         out_last     <= 1'b0;
      end else begin
         state        <= state_n;
         ti           <= ti_n;
         ei           <= ei_n;
         tok_id       <= tok_id_n;
         cnt          <= cnt_n;
         tok_addr     <= tok_addr_n;
         emb_addr     <= emb_addr_n;
         out_data     <= data_n;
         out_valid    <= valid_n;
         out_row_last <= row_last_n;
         out_last     <= last_n;
      end
   end

   always_comb begin
      state_n    = state;
      ti_n       = ti;
      ei_n       = ei;
      tok_id_n   = tok_id;
      cnt_n      = cnt;
      data_n     = out_data;
      valid_n    = out_valid;
      row_last_n = out_row_last;
      last_n     = out_last;
      unique case (state)
         IDLE: begin
            if (cs) begin
               cnt_n   = (tok_count > MAX_CNT) ? MAX_CNT : tok_count;
               ti_n    = '0;
               ei_n    = '0;
               state_n = (tok_count == '0) ? DONE : RD_TOK;
            end
         end
         RD_TOK:   state_n = WAIT_TOK;
         WAIT_TOK: begin
            tok_id_n = tok_data;
            ei_n     = '0;
            state_n  = RD_EMB;
         end
         RD_EMB:   state_n = WAIT_EMB;
         WAIT_EMB: begin
            data_n     = emb_data;
            valid_n    = 1'b1;
            row_last_n = ei_last;
            last_n     = ei_last && ti_last;
            state_n    = EMIT;
         end
         EMIT: begin
            if (out_ready) begin
               valid_n    = 1'b0;
               row_last_n = 1'b0;
               last_n     = 1'b0;
               if (!ei_last) begin
                  ei_n    = ei + EI_ONE;
                  state_n = RD_EMB;
               end else if (!ti_last) begin
                  ti_n    = ti + TI_ONE;
                  state_n = RD_TOK;
               end else begin
                  state_n = DONE;
               end
            end
         end
         DONE: if (!cs) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // Abort wins over a same-cycle handshake; the element is dropped.
      if (!cs && busy) begin
         state_n    = IDLE;
         ti_n       = ti;
         ei_n       = ei;
         tok_id_n   = tok_id;
         valid_n    = 1'b0;
         row_last_n = 1'b0;
         last_n     = 1'b0;
      end
   end

   assign tok_addr_n = (state_n == RD_TOK) ? ti_n : tok_addr;
   assign emb_addr_n = (state_n == RD_EMB) ? {tok_id_n, ei_n} : emb_addr;

endmodule

// File: doc/token_embedder.md
Name: token_embedder

Overview:
- Downstream stage of the encoder.
- Once the encoder has written token IDs into its output SRAM, this block reads the IDs back in order.
- For each ID it fetches an EMB_DIM-element embedding row from a synchronous embedding SRAM.
- It streams the elements out on a valid/ready interface toward the tensor datapath, then reports done.

Parameters:
- ADDR_WIDTH, 4, address width of the encoder output (token) SRAM; max tokens = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, width of token IDs and embedding elements.
- EMB_DIM, 4, elements per embedding row (power of two, >=2). Localparam EW = $clog2(EMB_DIM).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  chip select; level-enable for a run.
- tok_count  in  ADDR_WIDTH+1  number of valid tokens in the token SRAM; sampled on start.
- tok_rd  out  1  token SRAM read strobe.
- tok_addr  out  ADDR_WIDTH  token SRAM address.
- tok_data  in  DATA_WIDTH  token SRAM read data; valid the cycle after the tok_rd edge.
- emb_rd  out  1  embedding SRAM read strobe.
- emb_addr  out  DATA_WIDTH+EW  embedding address = {tok_id, ei}.
- emb_data  in  DATA_WIDTH  embedding read data; 1-cycle latency.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  DATA_WIDTH  embedding element.
- out_row_last  out  1  high with the last element of each row.
- out_last  out  1  high with the final element of the run.
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset: state=IDLE; ti=0, ei=0, tok_id=0, cnt=0.
- Reset values of outputs: tok_rd, emb_rd, out_valid, out_row_last, out_last, busy and done are 0; tok_addr, emb_addr and out_data are 0.
- Reset asserted mid-run aborts immediately; no partial output is held.
- FSM:
  - IDLE: if cs: latch cnt=tok_count, ti=0, ei=0. If tok_count==0 go to DONE, else go to RD_TOK.
  - RD_TOK: tok_rd=1, tok_addr=ti. Go to WAIT_TOK.
  - WAIT_TOK: tok_id<=tok_data, ei<=0. Go to RD_EMB.
  - RD_EMB: emb_rd=1, emb_addr={tok_id,ei}. Go to WAIT_EMB.
  - WAIT_EMB: out_data<=emb_data; out_valid<=1. out_row_last<=(ei==EMB_DIM-1). out_last<=(ei==EMB_DIM-1 && ti==cnt-1). Go to EMIT.
  - EMIT: hold out_valid and out_data stable until out_ready. On handshake, out_valid<=0, then:
    - ei<EMB_DIM-1: ei++, go to RD_EMB.
    - else if ti<cnt-1: ti++, go to RD_TOK.
    - else go to DONE.
  - DONE: done=1. Stay while cs=1; go to IDLE when cs=0. done clears on that edge.
- Strobes: tok_rd and emb_rd are single-cycle pulses. Addresses hold their last value when the strobes are low.
- Latency: cs sampled high at edge E0 → out_valid rises after E0+4.
- Throughput with out_ready held high: 3 cycles per element, plus 2 cycles per token fetch.
- Backpressure: out_ready low in EMIT stalls indefinitely; no SRAM reads are issued while stalled.
- cs dropped in any busy state: next edge goes to IDLE, out_valid=0, counters are kept and reloaded on the next start. An in-flight element is discarded.
- tok_count > 2**ADDR_WIDTH: clamp cnt to 2**ADDR_WIDTH.
- tok_count changing mid-run is ignored.
- ti never wraps; the run ends at ti==cnt-1.

Test Plan:
- Basic run:
  - Stimulus: EMB_DIM=4, embedding mem[a]=a+1; token SRAM = {3,0,5}; tok_count=3; cs=1; out_ready=1.
  - Response: 12 outputs 13,14,15,16, 1,2,3,4, 21,22,23,24.
  - out_row_last on outputs 4, 8 and 12; out_last only on output 12; done=1 after it.
  - First out_valid 4 cycles after cs is sampled.
- Zero tokens:
  - Stimulus: tok_count=0, cs=1.
  - Response: done=1 one edge later; no tok_rd, emb_rd or out_valid pulses.
- Backpressure:
  - Stimulus: basic run with out_ready low for 5 cycles during element 2.
  - Response: out_data=14 held stable with out_valid high for all 5 cycles; no emb_rd during the stall; sequence unchanged.
- Abort:
  - Stimulus: cs dropped while in EMIT of element 6.
  - Response: IDLE next edge, out_valid=0, busy=0. Re-asserting cs restarts from token 0, element 13.
- Async reset:
  - Stimulus: rst_n pulsed low mid-run, between clock edges.
  - Response: all outputs 0 immediately, without waiting for a clock edge.
- Max count:
  - Stimulus: tok_count=17 with ADDR_WIDTH=4.
  - Response: exactly 16 tokens (64 outputs) emitted; tok_addr runs 0..15 without wrapping.
